// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/mem/writeback and drives datapath selects/enables.
// Outputs are Moore from the current state. BRANCH pc_write is combinational from flags/funct3. No backpressure.
module multicycle_control_fsm #(
  parameter logic TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       Sign,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t state, state_nxt;
  logic   branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // blt/bge use the raw result sign; signed overflow is deliberately ignored
  always_comb begin
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = Sign;
      3'b101:  branch_taken = ~Sign;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = S_FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_nxt = S_MEMADR;
          7'b0110011:             state_nxt = S_EXECUTER;
          7'b0010011:             state_nxt = S_EXECUTEI;
          7'b1100011:             state_nxt = S_BRANCH;
          7'b1101111:             state_nxt = S_JAL;
          default:                state_nxt = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = branch_taken;
      end
      S_ILLEGAL: begin
        illegal   = 1'b1;
        state_nxt = S_ILLEGAL;
      end
      default: state_nxt = S_FETCH;
    endcase
    // Reset holds state at FETCH; suppress its enables so nothing commits while held
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: one trapping and one non-trapping instance share the same stimulus.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, Sign;

  logic       pc_write_t, adr_src_t, mem_write_t, ir_write_t, reg_write_t, illegal_t;
  logic [1:0] result_src_t, alu_src_a_t, alu_src_b_t, alu_op_t;
  logic [3:0] state_o_t;
  logic       pc_write_n, adr_src_n, mem_write_n, ir_write_n, reg_write_n, illegal_n;
  logic [1:0] result_src_n, alu_src_a_n, alu_src_b_n, alu_op_n;
  logic [3:0] state_o_n;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TRAP_ILLEGAL(1'b1)) dut_trap (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .Sign(Sign),
    .pc_write(pc_write_t), .adr_src(adr_src_t), .mem_write(mem_write_t), .ir_write(ir_write_t),
    .result_src(result_src_t), .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t), .alu_op(alu_op_t),
    .reg_write(reg_write_t), .illegal(illegal_t), .state_o(state_o_t)
  );

  multicycle_control_fsm #(.TRAP_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .Sign(Sign),
    .pc_write(pc_write_n), .adr_src(adr_src_n), .mem_write(mem_write_n), .ir_write(ir_write_n),
    .result_src(result_src_n), .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .alu_op(alu_op_n),
    .reg_write(reg_write_n), .illegal(illegal_n), .state_o(state_o_n)
  );

  logic [17:0] obs_t, obs_n;
  assign obs_t = {pc_write_t, adr_src_t, mem_write_t, ir_write_t, result_src_t, alu_src_a_t,
                  alu_src_b_t, alu_op_t, reg_write_t, illegal_t, state_o_t};
  assign obs_n = {pc_write_n, adr_src_n, mem_write_n, ir_write_n, result_src_n, alu_src_a_n,
                  alu_src_b_n, alu_op_n, reg_write_n, illegal_n, state_o_n};

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic s);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return s;
      3'd5:    return !s;
      default: return 1'b0;
    endcase
  endfunction

  // Expected output vector for a given state number, straight from the per-state output list
  function automatic logic [17:0] exp_out(input int st, input logic [2:0] f3, input logic z,
                                          input logic s, input logic in_rst);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, ao;
    logic [3:0] sv;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {rs, a, b, ao} = '0;
    sv = st[3:0];
    case (st)
      0:  begin irw = 1; b = 2'b10; rs = 2'b10; pcw = 1; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2'b10; ao = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      8:  rw = 1;
      9:  begin a = 2'b10; ao = 2'b01; pcw = taken(f3, z, s); end
      10: begin a = 2'b01; b = 2'b10; pcw = 1; end
      15: ill = 1;
      default: sv = 4'd0;
    endcase
    if (in_rst) {pcw, mw, irw, rw, ill} = '0;
    return {pcw, adr, mw, irw, rs, a, b, ao, rw, ill, sv};
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_trap"}, obs_t, exp_out(0, funct3, zero, Sign, 1'b1));
    check({tag, "_nop"},  obs_n, exp_out(0, funct3, zero, Sign, 1'b1));
  endtask

  // Runs one legal instruction from FETCH; optionally resets right after checking step abort_at
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input logic s, input int abort_at);
    int seq[$];
    op = o; funct3 = f3; zero = z; Sign = s;
    case (o)
      OP_LW:   seq = '{0, 1, 2, 3, 4};
      OP_SW:   seq = '{0, 1, 2, 5};
      OP_R:    seq = '{0, 1, 6, 8};
      OP_I:    seq = '{0, 1, 7, 8};
      OP_B:    seq = '{0, 1, 9};
      OP_JAL:  seq = '{0, 1, 10, 8};
      default: seq = '{0, 1};
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      @(negedge clk);
      check($sformatf("op%b_f%0d_step%0d_trap", o, f3, k), obs_t, exp_out(seq[k], f3, z, s, 1'b0));
      check($sformatf("op%b_f%0d_step%0d_nop", o, f3, k),  obs_n, exp_out(seq[k], f3, z, s, 1'b0));
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset($sformatf("abort_op%b_step%0d", o, k));
        @(posedge clk);
        #1;
        check_reset($sformatf("abort_hold_op%b", o));
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [6:0] ops[6];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL};
    rst_n = 1'b0; op = '0; funct3 = '0; zero = 1'b0; Sign = 1'b0;
    #1;
    check_reset("reset_initial");
    @(posedge clk); @(posedge clk); #1;
    check_reset("reset_held");
    rst_n = 1'b1;

    run_instr(OP_R,   3'd0, 1'b0, 1'b0, -1);
    run_instr(OP_LW,  3'd2, 1'b1, 1'b0, -1);
    run_instr(OP_B,   3'd0, 1'b1, 1'b0, -1);
    run_instr(OP_B,   3'd0, 1'b0, 1'b1, -1);
    run_instr(OP_B,   3'd6, 1'b1, 1'b1, -1);
    run_instr(OP_B,   3'd6, 1'b0, 1'b0, -1);
    run_instr(OP_B,   3'd1, 1'b0, 1'b0, -1);
    run_instr(OP_B,   3'd4, 1'b0, 1'b1, -1);
    run_instr(OP_B,   3'd5, 1'b1, 1'b1, -1);
    run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, -1);
    run_instr(OP_I,   3'd3, 1'b0, 1'b0, -1);
    run_instr(OP_SW,  3'd2, 1'b0, 1'b0, 3);
    run_instr(OP_SW,  3'd2, 1'b0, 1'b0, -1);

    for (int i = 0; i < 300; i++) begin
      int abort_at;
      abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), abort_at);
    end

    // Unknown opcode: trapping instance parks in ILLEGAL, the other keeps re-fetching
    op = 7'b1111111; funct3 = 3'd0; zero = 1'b1; Sign = 1'b0;
    @(negedge clk);
    check("ill_fetch_trap", obs_t, exp_out(0, funct3, zero, Sign, 1'b0));
    check("ill_fetch_nop",  obs_n, exp_out(0, funct3, zero, Sign, 1'b0));
    @(negedge clk);
    check("ill_decode_trap", obs_t, exp_out(1, funct3, zero, Sign, 1'b0));
    check("ill_decode_nop",  obs_n, exp_out(1, funct3, zero, Sign, 1'b0));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("ill_hold%0d_trap", i), obs_t, exp_out(15, funct3, zero, Sign, 1'b0));
      check($sformatf("ill_hold%0d_nop", i),  obs_n, exp_out(i % 2, funct3, zero, Sign, 1'b0));
      funct3 = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      Sign   = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("ill_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, -1);
    run_instr(OP_LW, 3'd2, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
